// File: rtl/pipe_alu.sv
// Multi-cycle ALU: one command in flight, barrel shifter on operand B,
// iterative shift-add multiplier, conditional execution against {N,Z,C,V}.
module pipe_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       cond,
  input  logic             s,
  input  logic [2:0]       sr_cont,
  input  logic [SHW-1:0]   sr_bit,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             wr_en,
  output logic             err,
  output logic [3:0]       flag
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             s_q, s_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [15:0]      imm_q, imm_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wr_en_q, wr_en_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       flag_q, flag_d;

  logic [WIDTH-1:0] b_shift;
  logic             cond_pass;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] res_w;
  logic             res_c;
  logic             res_v;
  logic             legal_w;

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign wr_en     = wr_en_q;
  assign err       = err_q;
  assign flag      = flag_q;

  always_comb begin
    b_shift = in2;
    case (sr_cont)
      3'b001: b_shift = in2 >> sr_bit;
      3'b010: b_shift = in2 << sr_bit;
      3'b011: begin
        if (sr_bit != '0) begin
          b_shift = (in2 >> sr_bit) | (in2 << (WIDTH - int'(sr_bit)));
        end
      end
      default: b_shift = in2;
    endcase
  end

  // flag_q is {N,Z,C,V}
  always_comb begin
    cond_pass = 1'b1;
    case (cond)
      4'b0000: cond_pass =  flag_q[2];
      4'b0001: cond_pass = !flag_q[2];
      4'b0010: cond_pass =  flag_q[1];
      4'b0011: cond_pass = !flag_q[1];
      4'b0100: cond_pass =  flag_q[3];
      4'b0101: cond_pass = !flag_q[3];
      4'b0110: cond_pass =  flag_q[0];
      4'b0111: cond_pass = !flag_q[0];
      default: cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    res_w   = '0;
    res_c   = flag_q[1];
    res_v   = flag_q[0];
    legal_w = 1'b1;
    case (op_q)
      OP_ADD: begin
        res_w = sum_w[WIDTH-1:0];
        res_c = sum_w[WIDTH];
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_w = diff_w[WIDTH-1:0];
        res_c = !diff_w[WIDTH];
        res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL:  res_w = acc_q;
      OP_OR:   res_w = a_q | b_q;
      OP_AND:  res_w = a_q & b_q;
      OP_XOR:  res_w = a_q ^ b_q;
      OP_MOVI: res_w = WIDTH'(imm_q);
      OP_MOV:  res_w = b_q;
      default: legal_w = 1'b0;
    endcase
  end

  // During MUL, a_q doubles as the multiplier and b_q as the multiplicand.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    s_d         = s_q;
    pass_d      = pass_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    wr_en_d     = wr_en_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    flag_d      = flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          s_d     = s;
          pass_d  = cond_pass;
          a_d     = in1;
          b_d     = b_shift;
          imm_d   = imm;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (opcode == OP_MUL && cond_pass) ? MUL : DONE;
        end
      end
      MUL: begin
        if (a_q[0]) begin
          acc_d = acc_q + b_q;
        end
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_d       = '0;
          wr_en_d     = 1'b0;
          err_d       = 1'b0;
          if (!legal_w) begin
            err_d = 1'b1;
          end else if (pass_q) begin
            out_d   = res_w;
            wr_en_d = (op_q != OP_CMP);
            if (s_q || op_q == OP_CMP) begin
              flag_d = {res_w[WIDTH-1], (res_w == '0), res_c, res_v};
            end
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      s_q         <= 1'b0;
      pass_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      wr_en_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      s_q         <= s_d;
      pass_q      <= pass_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      wr_en_q     <= wr_en_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu (WIDTH=32): directed vector table,
// randomized commands against an arithmetic reference model, reset-abort case.
module tb_pipe_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [3:0]    cond;
  logic          s;
  logic [2:0]    sr_cont;
  logic [4:0]    sr_bit;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [15:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          wr_en;
  logic          err;
  logic [3:0]    flag;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .cond(cond), .s(s), .sr_cont(sr_cont), .sr_bit(sr_bit),
    .in1(in1), .in2(in2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .wr_en(wr_en), .err(err), .flag(flag)
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  cnd;
    logic        sv;
    logic [2:0]  sc;
    logic [4:0]  sb;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] im;
    int          hold;
    logic [31:0] eo;
    logic        ew;
    logic        ee;
    logic [3:0]  ef;
    int          el;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference: operand B and result from plain integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [3:0] cnd, input logic sv,
                       input logic [2:0] sc, input logic [4:0] sb, input logic [31:0] a,
                       input logic [31:0] b_in, input logic [15:0] im, inout logic [3:0] f,
                       output logic [31:0] eo, output logic ew, output logic ee, output int el);
    logic [31:0]     b;
    longint unsigned bb, aa, r;
    longint          ss;
    bit              pass, legal, arith, c, v;
    b  = b_in;
    bb = 64'(b_in);
    case (sc)
      3'b001: b = b_in / (32'd1 << sb);
      3'b010: b = 32'(bb * (64'd1 << sb));
      3'b011: for (int k = 0; k < int'(sb); k++) b = {b[0], b[31:1]};
      default: b = b_in;
    endcase
    case (cnd)
      4'd0: pass = f[2];    4'd1: pass = !f[2];
      4'd2: pass = f[1];    4'd3: pass = !f[1];
      4'd4: pass = f[3];    4'd5: pass = !f[3];
      4'd6: pass = f[0];    4'd7: pass = !f[0];
      default: pass = 1'b1;
    endcase
    legal = (op <= 4'd7) || (op == 4'd11);
    aa = 64'(a);
    bb = 64'(b);
    ss = 0;
    arith = 1'b0;
    c = f[1];
    r = 0;
    case (op)
      4'd0:  begin r = aa + bb; c = (r >= 64'h1_0000_0000); arith = 1'b1;
                   ss = longint'(signed'(a)) + longint'(signed'(b)); end
      4'd1, 4'd11: begin r = aa - bb; c = (aa >= bb); arith = 1'b1;
                   ss = longint'(signed'(a)) - longint'(signed'(b)); end
      4'd2:  r = aa * bb;
      4'd3:  r = aa | bb;
      4'd4:  r = aa & bb;
      4'd5:  r = aa ^ bb;
      4'd6:  r = 64'(im);
      4'd7:  r = bb;
      default: r = 0;
    endcase
    eo = r[31:0];
    v  = arith ? (ss != longint'(signed'(eo))) : f[0];
    el = (legal && pass && op == 4'd2) ? 33 : 1;
    ew = 1'b0;
    ee = 1'b0;
    if (!legal) begin
      eo = '0;
      ee = 1'b1;
    end else if (!pass) begin
      eo = '0;
    end else begin
      ew = (op != 4'd11);
      if (sv || op == 4'd11) f = {eo[31], (eo == 0), c, v};
    end
  endtask

  task automatic exec(input vec_t v, input string tag);
    int          guard;
    int          lat;
    logic [31:0] o;
    logic        w, e;
    logic [3:0]  f;
    bit          stable, busy_ok;
    @(negedge clk);
    opcode = v.op; cond = v.cnd; s = v.sv; sr_cont = v.sc; sr_bit = v.sb;
    in1 = v.a; in2 = v.b; imm = v.im; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = 4'($urandom); cond = 4'($urandom); s = 1'($urandom);
    sr_cont = 3'($urandom); sr_bit = 5'($urandom);
    in1 = $urandom; in2 = $urandom; imm = 16'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    o = out; w = wr_en; e = err; f = flag;
    chk({tag, "_latency"}, 64'(lat), 64'(v.el));
    chk({tag, "_out"}, 64'(o), 64'(v.eo));
    chk({tag, "_wr_en"}, 64'(w), 64'(v.ew));
    chk({tag, "_err"}, 64'(e), 64'(v.ee));
    chk({tag, "_flag"}, 64'(f), 64'(v.ef));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      #1;
      if (out !== o || wr_en !== w || err !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    if (v.hold > 0) chk({tag, "_hold"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_handshake"}, 64'({out_valid, in_ready}), 64'b01);
    $display("txn %0d %s op=%b cond=%b s=%b a=%h b=%h out=%h wr=%b err=%b flag=%b lat=%0d",
             txn, tag, v.op, v.cnd, v.sv, v.a, v.b, o, w, e, f, lat);
    txn++;
  endtask

  vec_t        tbl[20];
  vec_t        rv;
  logic [3:0]  mflag;
  int          stale;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //         op       cond     s     sc      sb  in1           in2           imm       hold out           wr    err   flag     lat
    tbl[0]  = '{4'b0010, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h0000_0007, 32'h0000_0006, 16'h0, 0, 32'h0000_002A, 1'b1, 1'b0, 4'b0000, 33};
    tbl[1]  = '{4'b0000, 4'b1110, 1'b1, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0, 3, 32'h0000_0000, 1'b1, 1'b0, 4'b0110, 1};
    tbl[2]  = '{4'b0000, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h0000_0001, 32'h0000_0001, 16'h0, 0, 32'h0000_0002, 1'b1, 1'b0, 4'b0000, 1};
    tbl[3]  = '{4'b1011, 4'b1110, 1'b0, 3'b000, 5'd0, 32'h0000_0005, 32'h0000_0005, 16'h0, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b0110, 1};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 3'b000, 5'd0, 32'h0000_0002, 32'h0000_0003, 16'h0, 0, 32'h0000_0005, 1'b1, 1'b0, 4'b0110, 1};
    tbl[5]  = '{4'b0000, 4'b0001, 1'b0, 3'b000, 5'd0, 32'h0000_0002, 32'h0000_0003, 16'h0, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b0110, 1};
    tbl[6]  = '{4'b0111, 4'b1110, 1'b0, 3'b010, 5'd4, 32'h0000_0000, 32'h0000_0001, 16'h0, 0, 32'h0000_0010, 1'b1, 1'b0, 4'b0110, 1};
    tbl[7]  = '{4'b0111, 4'b1110, 1'b1, 3'b011, 5'd1, 32'h0000_0000, 32'h0000_0001, 16'h0, 0, 32'h8000_0000, 1'b1, 1'b0, 4'b1010, 1};
    tbl[8]  = '{4'b1011, 4'b1110, 1'b0, 3'b000, 5'd0, 32'h0000_0003, 32'h0000_0005, 16'h0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 4'b1000, 1};
    tbl[9]  = '{4'b0001, 4'b0011, 1'b1, 3'b000, 5'd0, 32'h8000_0000, 32'h0000_0001, 16'h0, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 4'b0011, 1};
    tbl[10] = '{4'b1101, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h1234_5678, 32'h0000_0001, 16'h0, 3, 32'h0000_0000, 1'b0, 1'b1, 4'b0011, 1};
    tbl[11] = '{4'b0010, 4'b0000, 1'b1, 3'b000, 5'd0, 32'h0000_0007, 32'h0000_0006, 16'h0, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b0011, 1};
    tbl[12] = '{4'b0110, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h0000_0000, 32'h0000_0000, 16'hABCD, 0, 32'h0000_ABCD, 1'b1, 1'b0, 4'b0011, 1};
    tbl[13] = '{4'b0101, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h1234_5678, 32'h1234_5678, 16'h0, 0, 32'h0000_0000, 1'b1, 1'b0, 4'b0111, 1};
    tbl[14] = '{4'b0000, 4'b1110, 1'b1, 3'b000, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 0, 32'h8000_0000, 1'b1, 1'b0, 4'b1001, 1};
    tbl[15] = '{4'b0111, 4'b1110, 1'b0, 3'b001, 5'd0, 32'h0000_0000, 32'hDEAD_BEEF, 16'h0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b1001, 1};
    tbl[16] = '{4'b0111, 4'b1110, 1'b0, 3'b011, 5'd0, 32'h0000_0000, 32'hDEAD_BEEF, 16'h0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b1001, 1};
    tbl[17] = '{4'b0011, 4'b1110, 1'b0, 3'b000, 5'd0, 32'hF0F0_0000, 32'h0000_F0F0, 16'h0, 0, 32'hF0F0_F0F0, 1'b1, 1'b0, 4'b1001, 1};
    tbl[18] = '{4'b0100, 4'b1110, 1'b1, 3'b000, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0, 0, 32'h00F0_00F0, 1'b1, 1'b0, 4'b0001, 1};
    tbl[19] = '{4'b1011, 4'b0110, 1'b0, 3'b000, 5'd0, 32'h8000_0000, 32'h0000_0001, 16'h0, 0, 32'h7FFF_FFFF, 1'b0, 1'b0, 4'b0011, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; cond = '0; s = 1'b0; sr_cont = '0; sr_bit = '0;
    in1 = '0; in2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_flag", 64'(flag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 20; i++) exec(tbl[i], "vec");

    mflag = tbl[19].ef;
    for (int i = 0; i < 150; i++) begin
      rv.op = 4'($urandom_range(0, 15));
      if (rv.op == 4'd2 && $urandom_range(0, 3) != 0) rv.op = 4'd0;
      rv.cnd  = 4'($urandom);
      rv.sv   = 1'($urandom);
      rv.sc   = 3'($urandom);
      rv.sb   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rv.a    = pick();
      rv.b    = pick();
      rv.im   = 16'($urandom);
      rv.hold = $urandom_range(0, 2);
      model(rv.op, rv.cnd, rv.sv, rv.sc, rv.sb, rv.a, rv.b, rv.im, mflag,
            rv.eo, rv.ew, rv.ee, rv.el);
      rv.ef = mflag;
      exec(rv, "rnd");
    end

    // Reset in the middle of a multiply must abort it without a late result.
    @(negedge clk);
    opcode = 4'b0010; cond = 4'b1110; s = 1'b1; sr_cont = 3'b000; sr_bit = '0;
    in1 = 32'h0000_0007; in2 = 32'h0000_0006; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_flag", 64'(flag), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    out_ready = 1'b0;
    chk("abort_no_stale", 64'(stale), 64'd0);

    // Flags were cleared, so an EQ-conditioned ADD must now fail.
    mflag = 4'b0000;
    rv = '{4'b0000, 4'b0000, 1'b1, 3'b000, 5'd0, 32'd2, 32'd3, 16'h0, 0, 32'h0, 1'b0, 1'b0, 4'b0, 1};
    model(rv.op, rv.cnd, rv.sv, rv.sc, rv.sb, rv.a, rv.b, rv.im, mflag,
          rv.eo, rv.ew, rv.ee, rv.el);
    rv.ef = mflag;
    exec(rv, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 16 to 64.
REQ-002 The block SHALL have local parameter SHW = clog2(WIDTH), giving the shift-amount width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: a command is presented.
REQ-007 Port in_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 Port opcode, input, 4 bits: operation select.
REQ-009 Port cond, input, 4 bits: condition code.
REQ-010 Port s, input, 1 bit: update flags.
REQ-011 Port sr_cont, input, 3 bits: shift type applied to in2.
REQ-012 Port sr_bit, input, SHW bits: shift amount.
REQ-013 Port in1 and port in2, input, WIDTH bits each: operands.
REQ-014 Port imm, input, 16 bits: immediate.
REQ-015 Port out_valid, output, 1 bit: a result is presented.
REQ-016 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-017 Port out, output, WIDTH bits: result.
REQ-018 Port wr_en, output, 1 bit: the result is to be written back.
REQ-019 Port err, output, 1 bit: illegal opcode.
REQ-020 Port flag, output, 4 bits: registered {N,Z,C,V}.

Function
REQ-021 Accept: a command SHALL be captured at a rising edge with in_valid=1 and in_ready=1; all command inputs are registered at that edge.
REQ-022 FSM: the block SHALL have states IDLE, MUL and DONE.
  - in_ready=1 only in IDLE.
  - Accept of a MUL whose cond passes: IDLE -> MUL.
  - Any other accept: IDLE -> DONE.
  - MUL -> DONE after WIDTH iteration cycles.
  - DONE -> IDLE at the edge where out_valid=1 and out_ready=1.
REQ-023 Shifter, applied to in2 before use as operand B:
  - sr_cont=001: logical shift right by sr_bit.
  - sr_cont=010: logical shift left by sr_bit.
  - sr_cont=011: rotate right by sr_bit.
  - sr_cont=000 or 100-111: no shift.
  - An amount of 0 SHALL be the identity for every shift type.
REQ-024 Opcodes; all arithmetic is modulo 2^WIDTH:
  - 0000: in1+B.
  - 0001: in1-B.
  - 0010: low WIDTH bits of in1*B.
  - 0011: in1|B.
  - 0100: in1&B.
  - 0101: in1^B.
  - 0110: zero-extended imm.
  - 0111: B.
  - 1011: CMP, computing in1-B.
REQ-025 MUL SHALL be an iterative shift-add of one bit per cycle, taking WIDTH cycles in state MUL.
REQ-026 Latency, measured from the accept edge k: out_valid SHALL rise after edge k+1 for single-cycle ops and after edge k+1+WIDTH for MUL.
REQ-027 Output hold: out, wr_en, err and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Flags SHALL update at entry to DONE, only when s=1 or the op is CMP, and only when cond passes.
  - N = out[WIDTH-1].
  - Z = (out==0).
  - ADD: C = carry-out.
  - SUB/CMP: C = NOT borrow.
  - ADD/SUB/CMP: V = signed overflow.
  - MUL, logical ops and MOV: update N and Z only; C and V are unchanged.
REQ-029 cond SHALL be evaluated against the flag register value at the accept edge:
  - 0000 EQ (Z), 0001 NE (!Z).
  - 0010 CS (C), 0011 CC (!C).
  - 0100 MI (N), 0101 PL (!N).
  - 0110 VS (V), 0111 VC (!V).
  - All other codes: always.
REQ-030 Cond fail: the op SHALL complete in single-cycle latency with out=0, wr_en=0, err=0, flags unchanged; a MUL SHALL NOT enter state MUL.
REQ-031 wr_en SHALL be 1 for a passing legal op except CMP; CMP SHALL present the difference on out with wr_en=0.
REQ-032 Illegal opcodes 1000, 1001, 1010, 1100-1111 SHALL give out=0, wr_en=0, err=1, flags unchanged, with single-cycle latency.
REQ-033 Back-to-back: because flags update before the block returns to IDLE, a command accepted after a CMP SHALL see the CMP's flags.

Reset
REQ-034 At a rising edge with rst_n=0 the block SHALL enter IDLE with out_valid=0, out=0, wr_en=0, err=0, flag=0000.
REQ-035 in_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-036 Reset mid-MUL or in DONE SHALL abort the operation; no result is presented after release.

Verification (WIDTH=32)
REQ-037 ADD, s=1, in1=FFFFFFFF, in2=1 -> out=0, flag=0110 (N=0,Z=1,C=1,V=0), out_valid one cycle after accept.
REQ-038 MUL, in1=7, in2=6, sr_cont=000 -> out=42, wr_en=1, out_valid after 33 edges, in_ready=0 throughout.
REQ-039 CMP 5,5, then ADD cond=0000 (EQ) 2+3 -> out=5, wr_en=1; the same ADD with cond=0001 (NE) -> out=0, wr_en=0.
REQ-040 MOV-reg, in2=1, sr_cont=010, sr_bit=4 -> out=10h; sr_cont=011, sr_bit=1 -> out=80000000h.
REQ-041 out_ready=0 for 3 cycles after a result -> out stable, in_ready=0; opcode=1101 -> err=1, wr_en=0, flags unchanged.
REQ-042 rst_n=0 at MUL cycle 10 -> next cycle out_valid=0, flag=0000; in_ready=1 one cycle after release; no stale result appears.
